multicycle_alu: RTL and testbench
=================================

MULTICYCLE_ALU -- requirements
Module: multicycle_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits (WIDTH >= 2).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request; sampled only in IDLE.
REQ-005 SHALL have port a  input  WIDTH  operand A; captured when start is accepted.
REQ-006 SHALL have port b  input  WIDTH  operand B; captured when start is accepted.
REQ-007 SHALL have port alucontrol  input  4  opcode; captured when start is accepted.
REQ-008 SHALL have port busy  output  1  high from the accepting edge until the edge that asserts done.
REQ-009 SHALL have port done  output  1  single-cycle pulse; result and flags valid from this cycle.
REQ-010 SHALL have port result  output  WIDTH  registered result; held until the next done.
REQ-011 SHALL have port zero  output  1  registered; result == 0.
REQ-012 SHALL have port carry  output  1  registered; carry-out for add, borrow (a < b unsigned) for sub, else 0.
REQ-013 SHALL have port overflow  output  1  registered; two's-complement overflow for add/sub, else 0.
REQ-014 SHALL have port negative  output  1  registered; result[WIDTH-1].
REQ-015 SHALL have port divzero  output  1  registered; set by div/rem with b == 0, else 0.

Function
REQ-016 SHALL implement opcodes: 0 add; 1 sub; 2 and; 3 or; 4 bitwise nor ~(a|b); 5 xor; 6 unsigned div quotient; 7 slt unsigned (result 1 or 0, zero-extended); 8 lsl a by b; 9 lsr a by b; 10 unsigned rem.
REQ-017 SHALL return result 0 with all flags 0 except zero=1 for opcodes 11-15; latency as single-cycle ops.
REQ-018 SHALL interpret the shift amount as the full unsigned b; for b >= WIDTH, result 0.
REQ-019 SHALL compute add/sub modulo 2^WIDTH; carry/overflow from a WIDTH+1-bit sum.
REQ-020 SHALL use FSM states IDLE, EXEC, DIV, DONE: IDLE->EXEC on start; EXEC->DIV for div/rem with b != 0, else EXEC->DONE; DIV->DONE after WIDTH iterations; DONE->IDLE unconditionally.
REQ-021 SHALL capture operands and opcode at edge E0 (start=1 in IDLE); non-div ops and div-by-zero drive done=1 in the cycle after edge E2; busy=1 after E0 and 0 after E2.
REQ-022 SHALL implement div/rem as restoring shift-subtract, one quotient bit per cycle in DIV, with done=1 in the cycle after edge E(WIDTH+2).
REQ-023 SHALL on b == 0 for div/rem give result all-ones (div) or a (rem), divzero=1, carry=overflow=0.
REQ-024 SHALL ignore start while busy=1 or in DONE, and SHALL leave captured operands unchanged.
REQ-025 SHALL keep result and flags stable from done until the next done; inputs may change freely while busy.
REQ-026 SHALL accept a new start in IDLE in the cycle immediately after done, giving back-to-back operation.

Reset
REQ-027 SHALL on reset=1, immediately and independent of clk, force state IDLE, busy=0, done=0, result=0, and all flags=0, including zero.
REQ-028 SHALL on reset asserted mid-operation, including mid-DIV, abandon it, produce no done pulse, and hold outputs at their reset values until the next completed operation.

Verification (WIDTH=8)
REQ-029 SHALL cover: add a=0xFF b=0x01 -> result 0x00, zero=1, carry=1, overflow=0, done 2 cycles after start cycle, busy for 2 cycles.
REQ-030 SHALL cover: sub a=0x80 b=0x01 -> result 0x7F, overflow=1, carry=0, negative=0; slt a=0x03 b=0x05 -> 0x01.
REQ-031 SHALL cover: div a=200 b=7 -> result 28 with done 10 cycles after start; rem same operands -> 4; start pulses during busy produce no extra done.
REQ-032 SHALL cover: div a=5 b=0 -> result 0xFF, divzero=1, done 2 cycles after start; rem a=5 b=0 -> 0x05, divzero=1.
REQ-033 SHALL cover: lsl a=0x01 b=9 -> 0x00, zero=1; lsr a=0x80 b=7 -> 0x01; opcode 12 -> result 0x00, zero=1.
REQ-034 SHALL cover: reset asserted 4 cycles into div 200/7 -> busy=0, result=0x00 with no clock edge needed, no done; a following add 2+3 -> 0x05.

Source files
------------

// File: rtl/multicycle_alu.sv
// Multi-cycle ALU: operands are captured on start. Single-cycle ops and
// division by zero finish two edges after the start edge. Unsigned div/rem
// use a restoring shift-subtract loop that resolves one quotient bit per cycle.
// Results and flags are held in output registers from one done pulse until
// the next one.
module multicycle_alu #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [3:0]       alucontrol,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             carry,
   output logic             overflow,
   output logic             negative,
   output logic             divzero
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_EXEC = 2'd1;
   localparam logic [1:0] S_DIV  = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   localparam logic [3:0] OP_ADD = 4'd0;
   localparam logic [3:0] OP_SUB = 4'd1;
   localparam logic [3:0] OP_AND = 4'd2;
   localparam logic [3:0] OP_OR  = 4'd3;
   localparam logic [3:0] OP_NOR = 4'd4;
   localparam logic [3:0] OP_XOR = 4'd5;
   localparam logic [3:0] OP_DIV = 4'd6;
   localparam logic [3:0] OP_SLT = 4'd7;
   localparam logic [3:0] OP_LSL = 4'd8;
   localparam logic [3:0] OP_LSR = 4'd9;
   localparam logic [3:0] OP_REM = 4'd10;

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
   logic [3:0]       op_q, op_d;
   logic [WIDTH-1:0] quo_q, quo_d, rem_q, rem_d, iter_q, iter_d;
   logic [WIDTH-1:0] pend_result_q, pend_result_d;
   logic             pend_carry_q, pend_carry_d, pend_ovf_q, pend_ovf_d;
   logic             pend_divzero_q, pend_divzero_d;
   logic             busy_q, busy_d, done_q, done_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             zero_q, zero_d, carry_q, carry_d, overflow_q, overflow_d;
   logic             negative_q, negative_d, divzero_q, divzero_d;

   logic [WIDTH:0]   add_sum, sub_diff, div_trial, div_sub;
   logic [WIDTH-1:0] alu_result, rem_next, quo_next;
   logic             alu_carry, alu_ovf, alu_divzero, div_ge, is_div_op;

   // Single-cycle datapath evaluated on the captured operands.
   always_comb begin
      // NOTE: every combinational output gets a default first, so no path can infer a latch.
      alu_result  = '0;
      alu_carry   = 1'b0;
      alu_ovf     = 1'b0;
      alu_divzero = 1'b0;
      add_sum     = {1'b0, a_q} + {1'b0, b_q};
      sub_diff    = {1'b0, a_q} - {1'b0, b_q};
      case (op_q)
         OP_ADD: begin
            alu_result = add_sum[WIDTH-1:0];
            alu_carry  = add_sum[WIDTH];
            alu_ovf    = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (add_sum[WIDTH-1] != a_q[WIDTH-1]);
         end
         OP_SUB: begin
            alu_result = sub_diff[WIDTH-1:0];
            alu_carry  = sub_diff[WIDTH];   // borrow out, i.e. a < b unsigned
            alu_ovf    = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (sub_diff[WIDTH-1] != a_q[WIDTH-1]);
         end
         OP_AND: alu_result = a_q & b_q;
         OP_OR:  alu_result = a_q | b_q;
         OP_NOR: alu_result = ~(a_q | b_q);
         OP_XOR: alu_result = a_q ^ b_q;
         // Div/rem reach this path only when b == 0.
         OP_DIV: begin
            alu_result  = '1;
            alu_divzero = 1'b1;
         end
         OP_REM: begin
            alu_result  = a_q;
            alu_divzero = 1'b1;
         end
         OP_SLT: alu_result = {{(WIDTH-1){1'b0}}, (a_q < b_q)};
         // Logical shifts by the full b; amounts >= WIDTH naturally give 0.
         OP_LSL: alu_result = a_q << b_q;
         OP_LSR: alu_result = a_q >> b_q;
         default: alu_result = '0;
      endcase
   end

   // One restoring-division step: shift the next dividend bit into the remainder, subtract if it fits.
   always_comb begin
      div_trial = {rem_q, quo_q[WIDTH-1]};
      div_sub   = div_trial - {1'b0, b_q};
      div_ge    = ~div_sub[WIDTH];
      rem_next  = div_ge ? div_sub[WIDTH-1:0] : div_trial[WIDTH-1:0];
      quo_next  = {quo_q[WIDTH-2:0], div_ge};
      is_div_op = (op_q == OP_DIV) || (op_q == OP_REM);
   end

   // Control FSM and next-state computation for every register.
   always_comb begin
      state_d        = state_q;
      a_d            = a_q;
      b_d            = b_q;
      op_d           = op_q;
      quo_d          = quo_q;
      rem_d          = rem_q;
      iter_d         = iter_q;
      pend_result_d  = pend_result_q;
      pend_carry_d   = pend_carry_q;
      pend_ovf_d     = pend_ovf_q;
      pend_divzero_d = pend_divzero_q;
      busy_d         = busy_q;
      done_d         = 1'b0;
      result_d       = result_q;
      zero_d         = zero_q;
      carry_d        = carry_q;
      overflow_d     = overflow_q;
      negative_d     = negative_q;
      divzero_d      = divzero_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               a_d     = a;
               b_d     = b;
               op_d    = alucontrol;
               busy_d  = 1'b1;
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            if (is_div_op && (b_q != '0)) begin
               quo_d   = a_q;
               rem_d   = '0;
               iter_d  = {{(WIDTH-1){1'b0}}, 1'b1};
               state_d = S_DIV;
            end else begin
               pend_result_d  = alu_result;
               pend_carry_d   = alu_carry;
               pend_ovf_d     = alu_ovf;
               pend_divzero_d = alu_divzero;
               state_d        = S_DONE;
            end
         end
         S_DIV: begin
            quo_d  = quo_next;
            rem_d  = rem_next;
            iter_d = iter_q << 1;
            // The marker bit reaches the MSB on the WIDTH-th iteration.
            if (iter_q[WIDTH-1]) begin
               pend_result_d  = (op_q == OP_DIV) ? quo_next : rem_next;
               pend_carry_d   = 1'b0;
               pend_ovf_d     = 1'b0;
               pend_divzero_d = 1'b0;
               state_d        = S_DONE;
            end
         end
         default: begin
            result_d   = pend_result_q;
            zero_d     = (pend_result_q == '0);
            negative_d = pend_result_q[WIDTH-1];
            carry_d    = pend_carry_q;
            overflow_d = pend_ovf_q;
            divzero_d  = pend_divzero_q;
            done_d     = 1'b1;
            busy_d     = 1'b0;
            state_d    = S_IDLE;
         end
      endcase
   end

   // State registers; reset abandons any operation in flight and clears all outputs at once.
   always_ff @(posedge clk or posedge reset) begin
      // NOTE: datapath registers are reset too, so no X ever reaches the outputs after a mid-operation reset.
      if (reset) begin
         state_q        <= S_IDLE;
         a_q            <= '0;
         b_q            <= '0;
         op_q           <= '0;
         quo_q          <= '0;
         rem_q          <= '0;
         iter_q         <= '0;
         pend_result_q  <= '0;
         pend_carry_q   <= 1'b0;
         pend_ovf_q     <= 1'b0;
         pend_divzero_q <= 1'b0;
         busy_q         <= 1'b0;
         done_q         <= 1'b0;
         result_q       <= '0;
         zero_q         <= 1'b0;
         carry_q        <= 1'b0;
         overflow_q     <= 1'b0;
         negative_q     <= 1'b0;
         divzero_q      <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples the pre-edge value of the others.
         state_q        <= state_d;
         a_q            <= a_d;
         b_q            <= b_d;
         op_q           <= op_d;
         quo_q          <= quo_d;
         rem_q          <= rem_d;
         iter_q         <= iter_d;
         pend_result_q  <= pend_result_d;
         pend_carry_q   <= pend_carry_d;
         pend_ovf_q     <= pend_ovf_d;
         pend_divzero_q <= pend_divzero_d;
         busy_q         <= busy_d;
         done_q         <= done_d;
         result_q       <= result_d;
         zero_q         <= zero_d;
         carry_q        <= carry_d;
         overflow_q     <= overflow_d;
         negative_q     <= negative_d;
         divzero_q      <= divzero_d;
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign result   = result_q;
   assign zero     = zero_q;
   assign carry    = carry_q;
   assign overflow = overflow_q;
   assign negative = negative_q;
   assign divzero  = divzero_q;

endmodule

// File: tb/tb_multicycle_alu.sv
// Self-checking bench for multicycle_alu (WIDTH=8): a table of directed
// vectors run back-to-back, then hand-written sequences covering start
// pulses during busy and a reset in the middle of a division.
module tb_multicycle_alu;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic [7:0] a, b;
   logic [3:0] alucontrol;
   logic       busy, done, zero, carry, overflow, negative, divzero;
   logic [7:0] result;

   int checks = 0;
   int errors = 0;
   logic [7:0] prev_result;

   // Expected flags are packed as {zero, carry, overflow, negative, divzero}.
   typedef struct {
      logic [3:0] op;
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] res;
      logic [4:0] flags;
      int         lat;
   } vec_t;

   vec_t vecs [22];

   multicycle_alu #(.WIDTH(8)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .a          (a),
      .b          (b),
      .alucontrol (alucontrol),
      .busy       (busy),
      .done       (done),
      .result     (result),
      .zero       (zero),
      .carry      (carry),
      .overflow   (overflow),
      .negative   (negative),
      .divzero    (divzero)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Issue one operation starting at the current (negedge) time and wait for done.
   // Returns at the negedge inside the done cycle.
   task automatic do_op(input logic [3:0] op, input logic [7:0] aa, input logic [7:0] bb,
                        output int lat, output int bcnt, output bit stable_ok);
      start      = 1'b1;
      alucontrol = op;
      a          = aa;
      b          = bb;
      @(negedge clk);
      start      = 1'b0;
      a          = 8'($urandom);
      b          = 8'($urandom);
      alucontrol = 4'($urandom);
      lat        = 0;
      bcnt       = 0;
      stable_ok  = 1'b1;
      while (done !== 1'b1 && lat < 40) begin
         if (busy === 1'b1) bcnt++;
         if (result !== prev_result) stable_ok = 1'b0;
         @(negedge clk);
         lat++;
      end
   endtask

   initial begin
      int lat, bcnt, n_done, first_lat;
      bit stable_ok;
      logic [7:0] got;

      vecs = '{
         '{4'd0,  8'hFF, 8'h01, 8'h00, 5'b11000, 2},   // add wraps to zero with carry
         '{4'd1,  8'h80, 8'h01, 8'h7F, 5'b00100, 2},   // sub signed overflow
         '{4'd7,  8'h03, 8'h05, 8'h01, 5'b00000, 2},   // slt
         '{4'd6,  8'd200, 8'd7, 8'd28, 5'b00000, 10},  // div
         '{4'd10, 8'd200, 8'd7, 8'd4,  5'b00000, 10},  // rem
         '{4'd6,  8'h05, 8'h00, 8'hFF, 5'b00011, 2},   // div by zero
         '{4'd10, 8'h05, 8'h00, 8'h05, 5'b00001, 2},   // rem by zero
         '{4'd8,  8'h01, 8'd9,  8'h00, 5'b10000, 2},   // lsl beyond width
         '{4'd9,  8'h80, 8'd7,  8'h01, 5'b00000, 2},   // lsr
         '{4'd12, 8'h55, 8'hAA, 8'h00, 5'b10000, 2},   // unused opcode
         '{4'd2,  8'hF0, 8'h3C, 8'h30, 5'b00000, 2},   // and
         '{4'd3,  8'hF0, 8'h0F, 8'hFF, 5'b00010, 2},   // or
         '{4'd4,  8'h0F, 8'hF0, 8'h00, 5'b10000, 2},   // nor
         '{4'd5,  8'hAA, 8'hFF, 8'h55, 5'b00000, 2},   // xor
         '{4'd1,  8'h03, 8'h05, 8'hFE, 5'b01010, 2},   // sub with borrow
         '{4'd0,  8'h7F, 8'h01, 8'h80, 5'b00110, 2},   // add signed overflow
         '{4'd8,  8'h03, 8'd2,  8'h0C, 5'b00000, 2},   // lsl
         '{4'd6,  8'hFF, 8'h01, 8'hFF, 5'b00010, 10},  // div by one
         '{4'd10, 8'h07, 8'd200, 8'h07, 5'b00000, 10}, // rem, divisor larger
         '{4'd15, 8'hFF, 8'hFF, 8'h00, 5'b10000, 2},   // unused opcode
         '{4'd0,  8'h80, 8'h80, 8'h00, 5'b11100, 2},   // add carry and overflow
         '{4'd9,  8'h80, 8'd8,  8'h00, 5'b10000, 2}    // lsr by exactly width
      };

      reset      = 1'b1;
      start      = 1'b0;
      a          = '0;
      b          = '0;
      alucontrol = '0;
      #2;
      check("reset_busy",   32'(busy), 32'd0);
      check("reset_done",   32'(done), 32'd0);
      check("reset_result", 32'(result), 32'd0);
      check("reset_flags",  32'({zero, carry, overflow, negative, divzero}), 32'd0);
      @(negedge clk);
      reset       = 1'b0;
      prev_result = 8'h00;

      // Table vectors, each issued in the cycle right after the previous done.
      for (int i = 0; i < 22; i++) begin
         do_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, bcnt, stable_ok);
         check($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
         check($sformatf("v%0d_busy_cycles", i), 32'(bcnt), 32'(vecs[i].lat));
         check($sformatf("v%0d_busy_at_done", i), 32'(busy), 32'd0);
         check($sformatf("v%0d_result", i), 32'(result), 32'(vecs[i].res));
         check($sformatf("v%0d_flags", i), 32'({zero, carry, overflow, negative, divzero}),
               32'(vecs[i].flags));
         check($sformatf("v%0d_held_while_busy", i), 32'(stable_ok), 32'd1);
         prev_result = vecs[i].res;
         @(negedge clk);
         check($sformatf("v%0d_done_pulse", i), 32'(done), 32'd0);
         check($sformatf("v%0d_result_held", i), 32'(result), 32'(vecs[i].res));
      end

      // Division with start pulses during busy: exactly one done, operands untouched.
      start      = 1'b1;
      a          = 8'd200;
      b          = 8'd7;
      alucontrol = 4'd6;
      @(negedge clk);
      n_done    = 0;
      first_lat = -1;
      got       = '0;
      for (int i = 0; i < 20; i++) begin
         start      = (i < 8);
         a          = 8'd1;
         b          = 8'd1;
         alucontrol = 4'd0;
         if (done === 1'b1) begin
            n_done++;
            if (first_lat < 0) first_lat = i;
            got = result;
         end
         @(negedge clk);
      end
      start = 1'b0;
      check("busy_start_done_count", 32'(n_done), 32'd1);
      check("busy_start_latency", 32'(first_lat), 32'd10);
      check("busy_start_result", 32'(got), 32'd28);

      // Reset four cycles into a division: outputs clear at once and no done follows.
      start      = 1'b1;
      a          = 8'd200;
      b          = 8'd7;
      alucontrol = 4'd6;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      check("pre_reset_busy", 32'(busy), 32'd1);
      #2 reset = 1'b1;
      #1;
      check("midreset_busy",   32'(busy), 32'd0);
      check("midreset_done",   32'(done), 32'd0);
      check("midreset_result", 32'(result), 32'd0);
      check("midreset_flags",  32'({zero, carry, overflow, negative, divzero}), 32'd0);
      @(negedge clk);
      reset  = 1'b0;
      n_done = 0;
      for (int i = 0; i < 15; i++) begin
         if (done === 1'b1) n_done++;
         @(negedge clk);
      end
      check("after_reset_no_done", 32'(n_done), 32'd0);
      check("after_reset_result",  32'(result), 32'd0);
      check("after_reset_busy",    32'(busy), 32'd0);
      prev_result = 8'h00;
      do_op(4'd0, 8'd2, 8'd3, lat, bcnt, stable_ok);
      check("post_reset_add_latency", 32'(lat), 32'd2);
      check("post_reset_add_result",  32'(result), 32'd5);
      check("post_reset_add_flags",   32'({zero, carry, overflow, negative, divzero}), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
